// File: rtl/gnn_layer_seq.sv
// gnn_layer_seq: time-multiplexed single GNN layer.
//   Self-inclusive neighbour aggregation over a runtime adjacency mask (one
//   node per cycle), then a dense N_IN -> N_OUT transform through one shared
//   dot-product unit (one (node, out) pair per cycle, out index innermost).
//
// Ports:
//   clk, rst         clock / asynchronous active-high reset
//   in_valid/ready   input batch handshake (accepted only in IDLE)
//   x_flat           features, x[n][f] = x_flat[(n*N_IN+f)*XW +: XW]
//   w_flat           weights,  w[f][o] = w_flat[(f*N_OUT+o)*WW +: WW]
//   adj              adj[i*N_NODES+j] = 1 means node j feeds node i
//   out_valid/ready  result handshake (held in DONE)
//   y_flat           results,  y[n][o] = y_flat[(n*N_OUT+o)*OW +: OW], signed
//   busy             high whenever the block is not IDLE
//
// Build option: define GNN_RELU_EN to clamp every stored result at zero.

module gnn_layer_seq #(
  parameter int N_NODES = 4,
  parameter int N_IN    = 4,
  parameter int N_OUT   = 4,
  parameter int XW      = 5,
  parameter int WW      = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_NODES*N_IN*XW-1:0]    x_flat,
  input  logic [N_IN*N_OUT*WW-1:0]      w_flat,
  input  logic [N_NODES*N_NODES-1:0]    adj,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_NODES*N_OUT*(XW+$clog2(N_NODES)+WW+$clog2(N_IN))-1:0] y_flat,
  output logic                          busy
);

  localparam int AGW = XW + $clog2(N_NODES);
  localparam int OW  = AGW + WW + $clog2(N_IN);
  localparam int NCW = (N_NODES > 1) ? $clog2(N_NODES) : 1;
  localparam int OCW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  typedef enum logic [1:0] {IDLE, AGGR, XFORM, DONE} state_t;

  state_t state, state_next;

  logic [NCW-1:0] node_cnt;
  logic [OCW-1:0] out_cnt;

  logic signed [XW-1:0]  x_r   [N_NODES][N_IN];
  logic signed [WW-1:0]  w_r   [N_IN][N_OUT];
  logic [N_NODES-1:0]    adj_r [N_NODES];
  logic signed [AGW-1:0] a_r   [N_NODES][N_IN];
  logic signed [OW-1:0]  y_r   [N_NODES][N_OUT];

  logic signed [AGW-1:0] agg_sum [N_IN];
  logic signed [OW-1:0]  acc;
  logic signed [OW-1:0]  a_ext;
  logic signed [OW-1:0]  w_ext;
  logic signed [OW-1:0]  y_next;

  logic last_node;
  logic last_out;
  logic accept;

  assign last_node = (node_cnt == NCW'(N_NODES - 1));
  assign last_out  = (out_cnt == OCW'(N_OUT - 1));
  assign accept    = (state == IDLE) && in_valid;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: AGGR walks the nodes, XFORM walks (node, out) pairs.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (in_valid) state_next = AGGR;
      AGGR:  if (last_node) state_next = XFORM;
      XFORM: if (last_node && last_out) state_next = DONE;
      DONE:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Aggregation for the current node. The self term is forced in, so the
  // diagonal adjacency bits never matter.
  always_comb begin
    for (int f = 0; f < N_IN; f++) begin
      agg_sum[f] = '0;
      for (int j = 0; j < N_NODES; j++) begin
        if ((NCW'(j) == node_cnt) || adj_r[node_cnt][j])
          agg_sum[f] = agg_sum[f] +
                       {{(AGW-XW){x_r[j][f][XW-1]}}, x_r[j][f]};
      end
    end
  end

  // Shared dot-product unit. Operands are sign-extended to OW first so the
  // truncated OW-bit product and sum are exact.
  always_comb begin
    acc   = '0;
    a_ext = '0;
    w_ext = '0;
    for (int f = 0; f < N_IN; f++) begin
      a_ext = {{(OW-AGW){a_r[node_cnt][f][AGW-1]}}, a_r[node_cnt][f]};
      w_ext = {{(OW-WW){w_r[f][out_cnt][WW-1]}}, w_r[f][out_cnt]};
      acc   = acc + a_ext * w_ext;
    end
`ifdef GNN_RELU_EN
    y_next = acc[OW-1] ? '0 : acc;
`else
    y_next = acc;
`endif
  end

  // Datapath and counters: capture on accept, store aggregates in AGGR,
  // store results in XFORM. y is only touched by XFORM writes and reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      node_cnt <= '0;
      out_cnt  <= '0;
      for (int n = 0; n < N_NODES; n++) begin
        adj_r[n] <= '0;
        for (int f = 0; f < N_IN; f++) begin
          x_r[n][f] <= '0;
          a_r[n][f] <= '0;
        end
        for (int o = 0; o < N_OUT; o++) y_r[n][o] <= '0;
      end
      for (int f = 0; f < N_IN; f++)
        for (int o = 0; o < N_OUT; o++) w_r[f][o] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            node_cnt <= '0;
            out_cnt  <= '0;
            for (int n = 0; n < N_NODES; n++) begin
              adj_r[n] <= adj[n*N_NODES +: N_NODES];
              for (int f = 0; f < N_IN; f++)
                x_r[n][f] <= x_flat[(n*N_IN+f)*XW +: XW];
            end
            for (int f = 0; f < N_IN; f++)
              for (int o = 0; o < N_OUT; o++)
                w_r[f][o] <= w_flat[(f*N_OUT+o)*WW +: WW];
          end
        end
        AGGR: begin
          for (int f = 0; f < N_IN; f++) a_r[node_cnt][f] <= agg_sum[f];
          node_cnt <= last_node ? '0 : node_cnt + NCW'(1);
          out_cnt  <= '0;
        end
        XFORM: begin
          y_r[node_cnt][out_cnt] <= y_next;
          if (last_out) begin
            out_cnt  <= '0;
            node_cnt <= last_node ? '0 : node_cnt + NCW'(1);
          end else begin
            out_cnt <= out_cnt + OCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Flatten the result registers onto the output bus.
  for (genvar n = 0; n < N_NODES; n++) begin : g_y_node
    for (genvar o = 0; o < N_OUT; o++) begin : g_y_out
      assign y_flat[(n*N_OUT+o)*OW +: OW] = y_r[n][o];
    end
  end

endmodule
